// File: rtl/mem_write_monitor.sv
// mem_write_monitor: in-order checker of CPU data-memory writes against a programmable table.
// Optional last-write capture ports enabled by defining MEM_MON_LAST_WRITE_EN.
module mem_write_monitor #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NUM_CHECKS = 2,
    parameter bit IGNORE_EN = 1,
    parameter int unsigned IGNORE_ADDR = 80,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int CNT_W = 32,
    localparam int IW = NUM_CHECKS > 1 ? $clog2(NUM_CHECKS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    input  logic              cfg_we,
    input  logic [IW-1:0]     cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              start,
    input  logic              clear,
    output logic              armed,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [IW-1:0]     fail_idx,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  ign_cnt,
`ifdef MEM_MON_LAST_WRITE_EN
    output logic [ADDR_W-1:0] last_addr,
    output logic [DATA_W-1:0] last_data,
    output logic              last_valid,
`endif
    output logic [CNT_W-1:0]  cycle_cnt
);
    typedef enum logic [2:0] {IDLE, ARMED, PASS, FAIL, TOUT} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] exp_addr [NUM_CHECKS];
    logic [DATA_W-1:0] exp_data [NUM_CHECKS];
    logic [IW-1:0] ptr;
    logic hit, ign, last, tmo, go, run, wr_hit, wr_ign, wr_bad;

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction

    always_comb begin
        hit = dataadr == exp_addr[ptr] && writedata == exp_data[ptr];
        ign = IGNORE_EN && dataadr == ADDR_W'(IGNORE_ADDR);
        last = ptr == IW'(NUM_CHECKS - 1);
        tmo = TIMEOUT_CYCLES != 0 && cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
        wr_hit = memwrite && hit;
        wr_ign = memwrite && !hit && ign;
        wr_bad = memwrite && !hit && !ign;
        go = state == IDLE && start && !clear;
        run = state == ARMED && !clear;
    end

    // A completing match or a mismatch on the timeout edge takes precedence.
    always_comb begin
        state_nx = state;
        if (clear)
            state_nx = IDLE;
        else if (go)
            state_nx = ARMED;
        else if (state == ARMED)
            state_nx = wr_hit && last ? PASS : wr_bad ? FAIL : tmo ? TOUT : ARMED;
    end

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    assign armed = state == ARMED;
    assign pass = state == PASS;
    assign fail = state == FAIL;
    assign timeout = state == TOUT;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                exp_addr[i] <= '0;
                exp_data[i] <= '0;
            end
            ptr <= '0;
            match_cnt <= '0;
            ign_cnt <= '0;
            cycle_cnt <= '0;
            fail_idx <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            if (state == IDLE && cfg_we && int'(cfg_idx) < NUM_CHECKS) begin
                exp_addr[cfg_idx] <= cfg_addr;
                exp_data[cfg_idx] <= cfg_data;
            end
            if (go) begin
                ptr <= '0;
                match_cnt <= '0;
                ign_cnt <= '0;
                cycle_cnt <= '0;
                fail_idx <= '0;
                fail_addr <= '0;
                fail_data <= '0;
            end
            if (run) begin
                cycle_cnt <= sat(cycle_cnt);
                if (wr_hit) begin
                    match_cnt <= sat(match_cnt);
                    if (!last)
                        ptr <= ptr + 1'b1;
                end
                if (wr_ign)
                    ign_cnt <= sat(ign_cnt);
                if (wr_bad) begin
                    fail_idx <= ptr;
                    fail_addr <= dataadr;
                    fail_data <= writedata;
                end
            end
        end
    end

`ifdef MEM_MON_LAST_WRITE_EN
    always_ff @(posedge clk) begin
        if (rst || go) begin
            last_addr <= '0;
            last_data <= '0;
            last_valid <= 1'b0;
        end else if (run && memwrite) begin
            last_addr <= dataadr;
            last_data <= writedata;
            last_valid <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_write_monitor.sv
// tb_mem_write_monitor: directed checks of mem_write_monitor with a 20-cycle timeout.
module tb_mem_write_monitor;
    logic clk = 0, rst, memwrite, cfg_we, start, clear;
    logic [31:0] dataadr, writedata, cfg_addr, cfg_data;
    logic cfg_idx;
    logic armed, pass, fail, timeout, fail_idx;
    logic [31:0] fail_addr, fail_data, match_cnt, ign_cnt, cycle_cnt;
`ifdef MEM_MON_LAST_WRITE_EN
    logic [31:0] last_addr, last_data;
    logic last_valid;
`endif
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    mem_write_monitor #(.TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst(rst), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .clear(clear), .armed(armed), .pass(pass), .fail(fail),
        .timeout(timeout), .fail_idx(fail_idx), .fail_addr(fail_addr), .fail_data(fail_data),
        .match_cnt(match_cnt), .ign_cnt(ign_cnt),
`ifdef MEM_MON_LAST_WRITE_EN
        .last_addr(last_addr), .last_data(last_data), .last_valid(last_valid),
`endif
        .cycle_cnt(cycle_cnt)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1; dataadr = a; writedata = d;
        tick(1);
        memwrite = 0;
    endtask

    task automatic cfg(input logic i, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1; cfg_idx = i; cfg_addr = a; cfg_data = d;
        tick(1);
        cfg_we = 0;
    endtask

    task automatic pulse_start();
        start = 1; tick(1); start = 0;
    endtask

    task automatic pulse_clear();
        clear = 1; tick(1); clear = 0;
    endtask

    initial begin
        {rst, memwrite, cfg_we, start, clear, cfg_idx} = '0;
        {dataadr, writedata, cfg_addr, cfg_data} = '0;
        rst = 1; tick(2); rst = 0;
        check("rst_armed", armed, 0);
        check("rst_status", {pass, fail, timeout}, 0);
        check("rst_match", match_cnt, 0);
        check("rst_cycle", cycle_cnt, 0);
        // basic pass with tolerated scratch writes
        cfg(0, 84, 7); cfg(1, 88, 9);
        pulse_start();
        check("arm", armed, 1);
        wr(80, 1); wr(84, 7); wr(80, 2);
        check("mid_armed", armed, 1);
        wr(88, 9);
        check("pass", pass, 1);
        check("pass_match", match_cnt, 2);
        check("pass_ign", ign_cnt, 2);
        check("pass_fail_tout", {fail, timeout, armed}, 0);
        check("pass_cycle", cycle_cnt, 4);
        tick(3);
        check("pass_sticky", pass, 1);
        check("pass_cycle_frozen", cycle_cnt, 4);
        pulse_clear();
        check("clear_pass", pass, 0);
        check("clear_hold_match", match_cnt, 2);
        // mismatch
        pulse_start();
        check("restart_match", match_cnt, 0);
        wr(84, 6);
        check("fail", fail, 1);
        check("fail_idx", fail_idx, 0);
        check("fail_addr", fail_addr, 84);
        check("fail_data", fail_data, 6);
        wr(84, 7); wr(88, 9);
        check("fail_sticky", {pass, fail}, 1);
        check("fail_match_frozen", match_cnt, 0);
        check("fail_addr_frozen", fail_addr, 84);
        pulse_clear();
        // timeout
        pulse_start();
        tick(19);
        check("tout_not_yet", timeout, 0);
        check("tout_cycle19", cycle_cnt, 19);
        tick(1);
        check("tout", timeout, 1);
        check("tout_cycle", cycle_cnt, 20);
        check("tout_pf", {pass, fail}, 0);
        tick(2);
        check("tout_cycle_frozen", cycle_cnt, 20);
        pulse_clear();
        // final match on the timeout edge wins
        pulse_start();
        tick(18);
        wr(84, 7); wr(88, 9);
        check("edge_pass", pass, 1);
        check("edge_tout", timeout, 0);
        check("edge_cycle", cycle_cnt, 20);
        pulse_clear();
        // reset mid-ARMED wipes the table
        pulse_start();
        wr(84, 7);
        check("pre_rst_match", match_cnt, 1);
        rst = 1; tick(1); rst = 0;
        check("rst2_armed", armed, 0);
        check("rst2_match", match_cnt, 0);
        check("rst2_cycle", cycle_cnt, 0);
        pulse_start();
        wr(0, 0);
        check("zero_match", match_cnt, 1);
        check("zero_armed", armed, 1);
        wr(0, 0);
        check("zero_pass", pass, 1);
        pulse_clear();
        // cfg ignored while ARMED
        cfg(0, 84, 7); cfg(1, 88, 9);
        pulse_start();
        cfg(0, 100, 5);
        wr(84, 7);
        check("armed_cfg_ignored", match_cnt, 1);
        pulse_clear();
        check("clear_armed", armed, 0);
        pulse_start();
        check("rearm", armed, 1);
        wr(84, 7); wr(88, 9);
        check("rearm_pass", pass, 1);
        check("rearm_match", match_cnt, 2);
        pulse_clear();
        // clear beats start
        start = 1; clear = 1; tick(1); start = 0; clear = 0;
        check("clear_beats_start", armed, 0);
        // cfg and start on the same edge: new entry used
        cfg_we = 1; cfg_idx = 1; cfg_addr = 90; cfg_data = 3; start = 1;
        tick(1);
        cfg_we = 0; start = 0;
        check("cfg_start_armed", armed, 1);
        wr(84, 7); wr(90, 3);
        check("cfg_start_pass", pass, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
